// File: rtl/video_stream_tx_pkg.sv
// Shared types, width helpers and default timing constants for the video stream transmitter.
// Used by video_stream_tx and video_timing_counter.
package video_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        V_PRE  = 2'd1,
        ACTIVE = 2'd2,
        V_POST = 2'd3
    } tx_state_t;

    // Never returns zero, so a count range of one still gets a 1-bit register.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int line_len(input int hdisp, input int hblank);
        return hdisp + hblank;
    endfunction

    function automatic int frame_period(input int hdisp, input int hblank,
                                        input int vpre, input int vdisp, input int vpost);
        return (vpre + vdisp + vpost) * line_len(hdisp, hblank);
    endfunction

    localparam int DEF_IMG_HDISP     = 1280;
    localparam int DEF_IMG_VDISP     = 720;
    localparam int DEF_H_BLANK       = 100;
    localparam int DEF_V_PRE_LINES   = 2;
    localparam int DEF_V_POST_LINES  = 4;
    localparam int DEF_LINE_LEN      = line_len(DEF_IMG_HDISP, DEF_H_BLANK);
    localparam int DEF_FRAME_PERIOD  = frame_period(DEF_IMG_HDISP, DEF_H_BLANK,
                                                    DEF_V_PRE_LINES, DEF_IMG_VDISP,
                                                    DEF_V_POST_LINES);

endpackage

// File: rtl/video_stream_tx_if.sv
// Source handshake and transmitted pixel stream of video_stream_tx.
// master is the transmitter side, slave is the source/sink side.
interface video_stream_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  tx_vs;
    logic                  tx_de;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  frame_start;
    logic                  frame_done;
    logic                  underflow;

    modport master (
        input  src_valid, src_data,
        output src_ready, tx_vs, tx_de, tx_data, frame_start, frame_done, underflow
    );

    modport slave (
        output src_valid, src_data,
        input  src_ready, tx_vs, tx_de, tx_data, frame_start, frame_done, underflow
    );
endinterface

// File: rtl/video_stream_tx_timing.sv
// video_timing_counter: horizontal/vertical position counter with wrap flags.
// hcnt wraps every LINE_LEN cycles; vcnt wraps after the line index given by last_v.
module video_timing_counter
    import video_tx_pkg::*;
#(
    parameter int LINE_LEN = DEF_LINE_LEN,
    parameter int HW       = cnt_width(LINE_LEN),
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [VW-1:0] last_v,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          last_pix,
    output logic          last_line
);

    assign last_pix  = (hcnt == HW'(LINE_LEN - 1));
    assign last_line = (vcnt == last_v);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (clear) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (last_pix) begin
            hcnt <= '0;
            vcnt <= last_line ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

endmodule

// File: rtl/video_stream_tx.sv
// Frame/line timing generator that pulls pixels from a valid/ready source and emits vs/de/data.
// Optional diagonal test pattern enabled by defining VIDEO_STREAM_TX_PATTERN_EN.
module video_stream_tx
    import video_tx_pkg::*;
#(
    parameter int IMG_HDISP    = DEF_IMG_HDISP,
    parameter int IMG_VDISP    = DEF_IMG_VDISP,
    parameter int H_BLANK      = DEF_H_BLANK,
    parameter int V_PRE_LINES  = DEF_V_PRE_LINES,
    parameter int V_POST_LINES = DEF_V_POST_LINES,
    parameter int DATA_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
`ifdef VIDEO_STREAM_TX_PATTERN_EN
    input  logic pattern_sel,
`endif
    video_stream_tx_if.master bus
);

    localparam int L  = line_len(IMG_HDISP, H_BLANK);
    localparam int HW = cnt_width(L);
    localparam int VW = cnt_width(max3(IMG_VDISP, V_PRE_LINES, V_POST_LINES));

    // state/hcnt/vcnt describe the cycle about to be presented, so every tx_* output
    // is a registered decode of them and src_ready falls one cycle ahead of tx_de.
    tx_state_t             state;
    tx_state_t             next_state;
    logic [HW-1:0]         hcnt;
    logic [VW-1:0]         vcnt;
    logic [VW-1:0]         last_v;
    logic                  last_pix;
    logic                  last_line;
    logic                  pix_due;
    logic                  pattern_mode;
    logic                  miss;
    logic                  at_frame_start;
    logic                  at_frame_end;
    logic [DATA_WIDTH-1:0] fill;
    logic [DATA_WIDTH-1:0] pix_data;

    video_timing_counter #(
        .LINE_LEN (L),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .last_v    (last_v),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .last_pix  (last_pix),
        .last_line (last_line)
    );

    always_comb begin
        last_v = '0;
        case (state)
            V_PRE:   last_v = VW'(V_PRE_LINES - 1);
            ACTIVE:  last_v = VW'(IMG_VDISP - 1);
            V_POST:  last_v = VW'(V_POST_LINES - 1);
            default: last_v = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = V_PRE;
            V_PRE:   if (last_pix && last_line) next_state = ACTIVE;
            ACTIVE:  if (last_pix && last_line) next_state = V_POST;
            V_POST:  if (last_pix && last_line) next_state = run ? V_PRE : IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef VIDEO_STREAM_TX_PATTERN_EN
    assign fill = DATA_WIDTH'(32'(hcnt) + 32'(vcnt));
`else
    assign fill         = '0;
    assign pattern_mode = 1'b0;
`endif

    assign pix_due        = (state == ACTIVE) && (hcnt < HW'(IMG_HDISP));
    assign bus.src_ready  = pix_due && !pattern_mode;
    assign miss           = bus.src_ready && !bus.src_valid;
    assign at_frame_start = (state == V_PRE) && (hcnt == '0) && (vcnt == '0);
    assign at_frame_end   = (state == ACTIVE) && last_pix && (vcnt == VW'(IMG_VDISP - 1));

    always_comb begin
        pix_data = '0;
        if (pix_due) pix_data = (bus.src_ready && bus.src_valid) ? bus.src_data : fill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.tx_vs       <= 1'b0;
            bus.tx_de       <= 1'b0;
            bus.tx_data     <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.underflow   <= 1'b0;
`ifdef VIDEO_STREAM_TX_PATTERN_EN
            pattern_mode    <= 1'b0;
`endif
        end else begin
            state           <= next_state;
            bus.tx_vs       <= (state == V_PRE) || (state == ACTIVE);
            bus.tx_de       <= pix_due;
            bus.tx_data     <= pix_data;
            bus.frame_start <= at_frame_start;
            bus.frame_done  <= at_frame_end;
            if (at_frame_start)
                bus.underflow <= 1'b0;
            else if (miss)
                bus.underflow <= 1'b1;
`ifdef VIDEO_STREAM_TX_PATTERN_EN
            if (at_frame_start)
                pattern_mode <= pattern_sel;
`endif
        end
    end

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench for video_stream_tx on a small 8x4 raster with a frame-position reference model.
// Pattern-frame checks are included when VIDEO_STREAM_TX_PATTERN_EN is defined.
module tb_video_stream_tx;

    localparam int HD     = 8;
    localparam int VD     = 4;
    localparam int HB     = 4;
    localparam int PRE    = 2;
    localparam int POST   = 2;
    localparam int DW     = 8;
    localparam int L      = HD + HB;
    localparam int FRAME  = (PRE + VD + POST) * L;
    localparam int VS_LEN = (PRE + VD) * L;
    localparam int ACT0   = PRE * L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
`ifdef VIDEO_STREAM_TX_PATTERN_EN
    logic pattern_sel = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] src_word;

    video_stream_tx_if #(.DATA_WIDTH(DW)) bus ();

    video_stream_tx #(
        .IMG_HDISP    (HD),
        .IMG_VDISP    (VD),
        .H_BLANK      (HB),
        .V_PRE_LINES  (PRE),
        .V_POST_LINES (POST),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
`ifdef VIDEO_STREAM_TX_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Frame-relative reference: k counts cycles from the first vs-high cycle.
    function automatic bit exp_de(input int k);
        if (k < ACT0 || k >= VS_LEN) return 1'b0;
        return ((k - ACT0) % L) < HD;
    endfunction

    function automatic logic [DW-1:0] ramp_at(input int k);
        int a;
        a = k - ACT0;
        return DW'((a % L) + (a / L));
    endfunction

    function automatic logic [DW-1:0] miss_fill(input int k);
`ifdef VIDEO_STREAM_TX_PATTERN_EN
        return ramp_at(k);
`else
        return (k < 0) ? DW'(1) : DW'(0);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [DW-1:0] data);
        bus.src_valid = valid;
        bus.src_data  = data;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " tx_vs"},       32'(bus.tx_vs),       32'(0));
        checkOutput({tag, " tx_de"},       32'(bus.tx_de),       32'(0));
        checkOutput({tag, " tx_data"},     32'(bus.tx_data),     32'(0));
        checkOutput({tag, " frame_start"}, 32'(bus.frame_start), 32'(0));
        checkOutput({tag, " frame_done"},  32'(bus.frame_done),  32'(0));
        checkOutput({tag, " underflow"},   32'(bus.underflow),   32'(0));
        checkOutput({tag, " src_ready"},   32'(bus.src_ready),   32'(0));
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("idle tx_vs@%0d", i),       32'(bus.tx_vs),       32'(0));
            checkOutput($sformatf("idle tx_de@%0d", i),       32'(bus.tx_de),       32'(0));
            checkOutput($sformatf("idle frame_start@%0d", i), 32'(bus.frame_start), 32'(0));
            checkOutput($sformatf("idle src_ready@%0d", i),   32'(bus.src_ready),   32'(0));
            applyStimulus($urandom_range(0, 1) == 1, DW'($urandom));
            @(negedge clk);
        end
    endtask

    task automatic waitFrameStart();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checkOutput($sformatf("pre-frame tx_vs@%0d", i), 32'(bus.tx_vs), 32'(0));
            @(negedge clk);
        end
        checkOutput("frame_start within budget", 32'(seen), 32'(1));
    endtask

    // data_mode 0: incrementing words from 0, 1: random words.
    // valid_mode 0: always valid, 1: drop pixel drop_pix only, 2: random drops.
    task automatic runFrame(input int data_mode, input int valid_mode, input int drop_pix,
                            input int run_off_k, input int rst_k, input bit pat);
        logic [DW-1:0] pend;
        bit uf;
        bit v;
        bit popped;
        int pix;
        pend = '0;
        uf   = 1'b0;
        pix  = 0;
        src_word = (data_mode == 0) ? DW'(0) : DW'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            checkOutput($sformatf("tx_vs@%0d", k),       32'(bus.tx_vs),       32'(k < VS_LEN));
            checkOutput($sformatf("tx_de@%0d", k),       32'(bus.tx_de),       32'(exp_de(k)));
            checkOutput($sformatf("tx_data@%0d", k),     32'(bus.tx_data),     32'(exp_de(k) ? pend : DW'(0)));
            checkOutput($sformatf("frame_start@%0d", k), 32'(bus.frame_start), 32'(k == 0));
            checkOutput($sformatf("frame_done@%0d", k),  32'(bus.frame_done),  32'(k == VS_LEN - 1));
            checkOutput($sformatf("underflow@%0d", k),   32'(bus.underflow),   32'(uf));
            checkOutput($sformatf("src_ready@%0d", k),   32'(bus.src_ready),   32'(exp_de(k + 1) && !pat));
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                checkAllZero($sformatf("async reset@%0d", k));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == run_off_k) run = 1'b0;
            v = (valid_mode == 2) ? ($urandom_range(0, 5) != 0) : 1'b1;
            popped = 1'b0;
            if (exp_de(k + 1)) begin
                if (valid_mode == 1 && pix == drop_pix) v = 1'b0;
                if (pat) begin
                    pend = ramp_at(k + 1);
                end else if (v) begin
                    pend   = src_word;
                    popped = 1'b1;
                end else begin
                    pend = miss_fill(k + 1);
                    uf   = 1'b1;
                end
                pix++;
            end
            applyStimulus(v, src_word);
            if (popped) src_word = (data_mode == 0) ? src_word + DW'(1) : DW'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        applyStimulus(1'b0, '0);
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);
        idleCheck(4);

        // Back-to-back frames: incrementing data, random data, then random drops with run released mid-ACTIVE.
        run = 1'b1;
        waitFrameStart();
        runFrame(0, 0, -1, -1, -1, 1'b0);
        runFrame(1, 0, -1, -1, -1, 1'b0);
        runFrame(1, 2, -1, 50, -1, 1'b0);
        idleCheck(30);

        // Single-cycle run pulse, one missing source word at pixel 5 of line 2.
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        waitFrameStart();
        runFrame(0, 1, 2 * HD + 5, -1, -1, 1'b0);
        idleCheck(30);

        // Asynchronous reset at the 4th pixel of line 1, then a clean restart.
        run = 1'b1;
        waitFrameStart();
        runFrame(0, 0, -1, -1, ACT0 + L + 3, 1'b0);
        waitFrameStart();
        runFrame(1, 2, -1, 30, -1, 1'b0);
        idleCheck(30);

`ifdef VIDEO_STREAM_TX_PATTERN_EN
        pattern_sel = 1'b1;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        waitFrameStart();
        runFrame(1, 2, -1, -1, -1, 1'b1);
        pattern_sel = 1'b0;
        idleCheck(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
